serializador_bits: RTL

SERIALIZADOR_BITS -- requirements
Module: serializador_bits

---
 rtl/serializador_bits.sv | 109 ++++++++++
 1 files changed

// File: rtl/serializador_bits.sv
// Parallel-to-serial transmitter: MSB first, one bit per cycle, optional even-parity bit.
// Build option: define PARIDAD_EN to append the parity bit after the data bits.
module serializador_bits #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ANCHO-1:0] dato,
    input  logic             valido,
    output logic             listo,
    output logic             salida_bit,
    output logic             activo,
    output logic [1:0]       estado,
    output logic [7:0]       palabras
);

    // Handshake: a word is taken on a rising edge where valido=1 and listo=1;
    // listo is high only while idle, and valido/dato are ignored at all other times.

    localparam int CW = (ANCHO > 2) ? $clog2(ANCHO) : 1;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        DESPLAZA = 2'd1,
        PARIDAD  = 2'd2
    } estado_t;

    estado_t          est_q;
    estado_t          est_d;
    logic [ANCHO-1:0] sr_q;
    logic [CW-1:0]    cnt_q;
    logic [7:0]       palabras_q;
    logic             carga;
    logic             fin_palabra;
`ifdef PARIDAD_EN
    logic             par_q;
`endif

    always_comb begin
        est_d       = est_q;
        carga       = 1'b0;
        fin_palabra = 1'b0;
        listo       = 1'b0;
        salida_bit  = 1'b0;
        activo      = 1'b0;
        case (est_q)
            REPOSO: begin
                listo = 1'b1;
                if (valido) begin
                    carga = 1'b1;
                    est_d = DESPLAZA;
                end
            end
            DESPLAZA: begin
                activo     = 1'b1;
                salida_bit = sr_q[ANCHO-1];
                if (cnt_q == '0) begin
`ifdef PARIDAD_EN
                    est_d       = PARIDAD;
`else
                    est_d       = REPOSO;
                    fin_palabra = 1'b1;
`endif
                end
            end
`ifdef PARIDAD_EN
            PARIDAD: begin
                activo      = 1'b1;
                salida_bit  = par_q;
                est_d       = REPOSO;
                fin_palabra = 1'b1;
            end
`endif
            // Unused code (and PARIDAD when the option is off) falls back to idle.
            default: est_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            est_q      <= REPOSO;
            sr_q       <= '0;
            cnt_q      <= '0;
            palabras_q <= '0;
`ifdef PARIDAD_EN
            par_q      <= 1'b0;
`endif
        end else begin
            est_q <= est_d;
            if (carga) begin
                sr_q  <= dato;
                cnt_q <= CW'(ANCHO - 1);
`ifdef PARIDAD_EN
                par_q <= ^dato;
`endif
            end else if (est_q == DESPLAZA) begin
                sr_q <= {sr_q[ANCHO-2:0], 1'b0};
                if (cnt_q != '0)
                    cnt_q <= cnt_q - CW'(1);
            end
            if (fin_palabra)
                palabras_q <= palabras_q + 8'd1;
        end
    end

    assign estado   = est_q;
    assign palabras = palabras_q;

endmodule
